mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
CPU-side initiator for the 16-bit byte-addressed, little-endian memory bus (op/addr/data, 0 = READ, 1 = WRITE). It accepts load/store requests from the core over a valid/ready handshake and drives the memory's op, address and write data. It samples the memory's combinational read data after a programmable wait. Byte stores are converted into a read-modify-write, because the memory only writes whole 16-bit words.

Parameters:
WAIT_CYCLES, 0, extra cycles the read address is held stable before mem_rdata is sampled (0..15).

Ports:
clk  in  1  clock; all state updates on the rising edge
reset_n  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request; high only in IDLE
req_write  in  1  1 = store, 0 = load
req_byte  in  1  1 = byte access, 0 = 16-bit word access
req_signed  in  1  byte load only: 1 = sign-extend, 0 = zero-extend
req_addr  in  16  byte address; any alignment allowed
req_wdata  in  16  store data; byte store uses [7:0]
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  16  load result; 0x0000 for stores
mem_op  out  1  memory op: 0 = READ, 1 = WRITE
mem_addr  out  16  memory address
mem_wdata  out  16  memory write data
mem_wdata_oe  out  1  drive enable for the shared data bus; equals mem_op
mem_rdata  in  16  memory read data, combinational from mem_addr

Behaviour:
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_rdata 0x0000, mem_op 0, mem_addr 0x0000, mem_wdata 0x0000, mem_wdata_oe 0.
- Accept:
  - A request is accepted on a rising edge where req_valid & req_ready.
  - addr, wdata, write, byte and signed are latched at that edge; later input changes are ignored.
  - req_valid while busy is ignored; no queuing.
- States: IDLE, RD, WR, RMW_RD, RMW_WR, RESP.
- IDLE: on accept, go to RD (load), WR (word store) or RMW_RD (byte store).
- RD:
  - mem_op 0, mem_addr = latched addr.
  - A wait counter holds the state for WAIT_CYCLES+1 cycles.
  - On the final edge, register the result:
    - word load: mem_rdata.
    - byte load: {8{signed & mem_rdata[7]}, mem_rdata[7:0]}.
  - Then go to RESP.
- WR:
  - One cycle: mem_op 1, mem_wdata_oe 1, mem_wdata = latched wdata.
  - Memory commits on the closing edge; go to RESP.
- RMW_RD:
  - Same timing as RD.
  - On the final edge, capture hi = mem_rdata[15:8]; go to RMW_WR.
- RMW_WR:
  - One cycle writing {hi, wdata[7:0]} to addr; mem[addr+1] is preserved.
  - Go to RESP.
- RESP:
  - resp_valid 1 for exactly one cycle; go to IDLE.
  - resp_rdata holds its value until the next RESP; it is set to 0x0000 for stores.
- Latency, counted from the accepting edge E0 to the edge after which resp_valid is high:
  - load: WAIT_CYCLES+2
  - word store: 2
  - byte store: WAIT_CYCLES+3
  - req_ready returns high one edge after RESP.
- Bus rules:
  - mem_op and mem_wdata_oe are 1 only in WR and RMW_WR; never in the same cycle as a read sample.
  - mem_addr is held stable for the whole operation and keeps its last value in IDLE.
- Address wrap: the memory accesses addr and addr+1 mod 2^16. A word access at 0xFFFF touches bytes 0xFFFF and 0x0000; no special handling in this block.
- Reset mid-operation: reset_n low immediately forces reset values, including mem_op 0.
  - A store whose write edge has not yet occurred is not performed.
  - An RMW aborted after RMW_RD leaves memory unchanged.
  - No resp_valid is issued for the aborted request.

Test Plan:
1. Word store 0xBEEF to 0x0010, then word load 0x0010 -> mem[0x10]=0xEF, mem[0x11]=0xBE; resp_rdata 0xBEEF; store resp_valid 2 edges after accept.
2. After 1, byte store 0x5A to 0x0010 -> mem[0x10]=0x5A, mem[0x11] still 0xBE; word load gives 0xBE5A; no write cycle carries {other, 0x5A} except at addr 0x0010.
3. mem[0x20]=0xEF: signed byte load -> 0xFFEF; unsigned -> 0x00EF; mem[0x20]=0x7F signed -> 0x007F.
4. WAIT_CYCLES=3, word load -> resp_valid after accept+5 edges; mem_op 0 throughout; req_valid held high during busy accepts only one request; a back-to-back request is accepted in the next IDLE.
5. Word store 0x1234 at 0xFFFF -> mem[0xFFFF]=0x34, mem[0x0000]=0x12; word load 0xFFFF returns 0x1234.
6. Byte store to 0x0030 (old 0xAAAA) with reset_n pulsed low during RMW_RD -> outputs at reset values asynchronously, no resp_valid, mem word at 0x0030 still 0xAAAA, req_ready 1 after release.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Core/memory-side bus bundle for mem_access_unit.
// The unit connects through the slave modport; the core and the memory
// (or a bench standing in for both) connect through the master modport.
interface mem_access_unit_if;
   // core request channel
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic        req_byte;
   logic        req_signed;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   // completion channel
   logic        resp_valid;
   logic [15:0] resp_rdata;
   // memory bus
   logic        mem_op;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_wdata_oe;
   logic [15:0] mem_rdata;

   modport slave (
      input  req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
      input  mem_rdata,
      output req_ready, resp_valid, resp_rdata,
      output mem_op, mem_addr, mem_wdata, mem_wdata_oe
   );

   modport master (
      output req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
      output mem_rdata,
      input  req_ready, resp_valid, resp_rdata,
      input  mem_op, mem_addr, mem_wdata, mem_wdata_oe
   );
endinterface

// File: rtl/mem_access_unit.sv
// CPU-side initiator for the 16-bit byte-addressed little-endian memory bus.
// Loads hold the address for WAIT_CYCLES+1 cycles and sample mem_rdata on the
// last edge. Word stores are a single write cycle. Byte stores become a
// read-modify-write: the upper byte of the addressed word is read back and
// rewritten unchanged alongside the new low byte.
module mem_access_unit #(
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic clk,
   input  logic reset_n,
   mem_access_unit_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_RD     = 3'd1,
      S_WR     = 3'd2,
      S_RMW_RD = 3'd3,
      S_RMW_WR = 3'd4,
      S_RESP   = 3'd5
   } state_t;

   // Final value of the wait counter: the read phase lasts r_cnt = 0..W_LAST.
   localparam logic [3:0] W_LAST = 4'(WAIT_CYCLES);

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic        r_byte;
   logic        r_signed;
   logic [7:0]  r_wdata_lo;
   logic        r_req_ready;
   logic        r_resp_valid;
   logic [15:0] r_resp_rdata;
   logic        r_mem_op;
   logic [15:0] r_mem_addr;
   logic [15:0] r_mem_wdata;

   logic        w_read_done;
   logic [15:0] w_load_result;

   // Last cycle of a read phase (RD or RMW_RD) is reached when the counter hits W_LAST.
   assign w_read_done = (r_cnt == W_LAST);

   // Load result formatting: byte loads take the addressed (low) byte, optionally sign-extended.
   assign w_load_result = r_byte ? {{8{r_signed & bus.mem_rdata[7]}}, bus.mem_rdata[7:0]}
                                 : bus.mem_rdata;

   // Control FSM with all bus-facing outputs registered; the address register doubles
   // as the latched request address so it stays stable and persists into IDLE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_cnt        <= 4'd0;
         r_byte       <= 1'b0;
         r_signed     <= 1'b0;
         r_wdata_lo   <= 8'h00;
         r_req_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= 16'h0000;
         r_mem_op     <= 1'b0;
         r_mem_addr   <= 16'h0000;
         r_mem_wdata  <= 16'h0000;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.req_valid && r_req_ready) begin
                  r_req_ready <= 1'b0;
                  r_mem_addr  <= bus.req_addr;
                  r_byte      <= bus.req_byte;
                  r_signed    <= bus.req_signed;
                  r_wdata_lo  <= bus.req_wdata[7:0];
                  r_cnt       <= 4'd0;
                  if (!bus.req_write) begin
                     r_state <= S_RD;
                  end else if (bus.req_byte) begin
                     r_state <= S_RMW_RD;
                  end else begin
                     // Word store goes straight to the bus in the next cycle.
                     r_state     <= S_WR;
                     r_mem_op    <= 1'b1;
                     r_mem_wdata <= bus.req_wdata;
                  end
               end
            end

            S_RD: begin
               if (w_read_done) begin
                  r_resp_rdata <= w_load_result;
                  r_resp_valid <= 1'b1;
                  r_state      <= S_RESP;
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end

            S_RMW_RD: begin
               if (w_read_done) begin
                  // Keep the neighbouring byte (addr+1) exactly as read.
                  r_mem_wdata <= {bus.mem_rdata[15:8], r_wdata_lo};
                  r_mem_op    <= 1'b1;
                  r_state     <= S_RMW_WR;
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end

            S_WR, S_RMW_WR: begin
               // Memory commits on this edge; the bus returns to read.
               r_mem_op     <= 1'b0;
               r_resp_rdata <= 16'h0000;
               r_resp_valid <= 1'b1;
               r_state      <= S_RESP;
            end

            S_RESP: begin
               r_resp_valid <= 1'b0;
               r_req_ready  <= 1'b1;
               r_state      <= S_IDLE;
            end

            default: begin
               r_mem_op     <= 1'b0;
               r_resp_valid <= 1'b0;
               r_req_ready  <= 1'b1;
               r_state      <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready    = r_req_ready;
   assign bus.resp_valid   = r_resp_valid;
   assign bus.resp_rdata   = r_resp_rdata;
   assign bus.mem_op       = r_mem_op;
   assign bus.mem_wdata_oe = r_mem_op;
   assign bus.mem_addr     = r_mem_addr;
   assign bus.mem_wdata    = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a byte-array memory answers the bus, a
// transaction-level model predicts every output each cycle, and directed
// requests carry hand-computed expected results.
module tb_mem_access_unit;
   localparam int TB_WAIT = 3;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   mem_access_unit_if bus ();

   mem_access_unit #(.WAIT_CYCLES(TB_WAIT)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int total = 0;
   int bad   = 0;

   // ---------------- memory: combinational read, write on rising edge ----------------
   logic [7:0] mem [0:65535];
   assign bus.mem_rdata = {mem[16'(bus.mem_addr + 16'd1)], mem[bus.mem_addr]};

   always @(posedge clk) begin
      if (bus.mem_op) begin
         mem[bus.mem_addr]                <= bus.mem_wdata[7:0];
         mem[16'(bus.mem_addr + 16'd1)]   <= bus.mem_wdata[15:8];
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- transaction model ----------------
   // One request at a time. Latency L counts edges from the accepting edge
   // (inclusive) up to the edge that raises resp_valid; a store's single write
   // cycle is the cycle right before the response cycle.
   logic [7:0]  mm [0:65535];
   bit          m_busy, m_resp, m_wr, m_byte, m_sgn;
   int          m_n, m_lat;
   logic [15:0] m_addr, m_wdata, m_rdata;

   task automatic model_finish();
      logic [15:0] a1;
      logic [7:0]  lo, hi;
      a1 = 16'(m_addr + 16'd1);
      lo = mm[m_addr];
      hi = mm[a1];
      if (!m_wr) begin
         if (m_byte) m_rdata = {(m_sgn && lo[7]) ? 8'hFF : 8'h00, lo};
         else        m_rdata = {hi, lo};
      end else begin
         m_rdata = 16'h0000;
         mm[m_addr] = m_wdata[7:0];
         if (!m_byte) mm[a1] = m_wdata[15:8];
      end
   endtask

   // Compare process: at each falling edge check outputs against the model,
   // then step the model to what the next rising edge will produce.
   initial begin
      logic exp_op;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            m_busy = 0; m_resp = 0; m_rdata = 16'h0000; m_addr = 16'h0000;
         end
         exp_op = m_busy && m_wr && !m_resp && (m_n == m_lat - 2);
         chk("req_ready",    32'(bus.req_ready),    32'(!m_busy));
         chk("resp_valid",   32'(bus.resp_valid),   32'(m_resp));
         chk("resp_rdata",   32'(bus.resp_rdata),   32'(m_rdata));
         chk("mem_op",       32'(bus.mem_op),       32'(exp_op));
         chk("mem_wdata_oe", 32'(bus.mem_wdata_oe), 32'(exp_op));
         chk("mem_addr",     32'(bus.mem_addr),     32'(m_addr));
         if (exp_op) begin
            if (m_byte) chk("mem_wdata", 32'(bus.mem_wdata),
                            32'({mm[16'(m_addr + 16'd1)], m_wdata[7:0]}));
            else        chk("mem_wdata", 32'(bus.mem_wdata), 32'(m_wdata));
         end
         if (reset_n) begin
            if (m_busy) begin
               m_n++;
               if (m_resp) begin
                  m_resp = 0;
                  m_busy = 0;
               end else if (m_n == m_lat - 1) begin
                  m_resp = 1;
                  model_finish();
               end
            end else if (bus.req_valid) begin
               m_busy  = 1;
               m_n     = 0;
               m_wr    = bus.req_write;
               m_byte  = bus.req_byte;
               m_sgn   = bus.req_signed;
               m_addr  = bus.req_addr;
               m_wdata = bus.req_wdata;
               if (!m_wr)       m_lat = TB_WAIT + 2;
               else if (m_byte) m_lat = TB_WAIT + 3;
               else             m_lat = 2;
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic do_req(input bit wr, input bit byt, input bit sgn,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         input bit hold,
                         output logic [15:0] rdata, output int lat, output int acc_wait);
      bit acc;
      bit rdy;
      acc = 0;
      acc_wait = 0;
      lat = 0;
      rdata = 16'h0000;
      bus.req_write  = wr;
      bus.req_byte   = byt;
      bus.req_signed = sgn;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      bus.req_valid  = 1'b1;
      while (!acc && acc_wait < 50) begin
         @(negedge clk);
         rdy = bus.req_ready;
         @(posedge clk);
         acc_wait++;
         if (rdy) acc = 1;
      end
      if (!acc) begin
         chk("accept_timeout", 32'(acc), 32'd1);
         bus.req_valid = 1'b0;
         return;
      end
      #1;
      if (!hold) begin
         bus.req_valid = 1'b0;
      end else begin
         // Still asserted while busy, with changed fields that must be ignored.
         bus.req_addr  = ~addr;
         bus.req_wdata = ~wdata;
         bus.req_write = ~wr;
      end
      lat = 1;
      while (!bus.resp_valid && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (!bus.resp_valid) chk("resp_timeout", 32'(bus.resp_valid), 32'd1);
      rdata = bus.resp_rdata;
      $display("txn wr=%0d byte=%0d signed=%0d addr=%h wdata=%h -> rdata=%h lat=%0d",
               wr, byt, sgn, addr, wdata, rdata, lat);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      logic [15:0] rd;
      int lat, aw, n;
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_byte   = 1'b0;
      bus.req_signed = 1'b0;
      bus.req_addr   = 16'h0000;
      bus.req_wdata  = 16'h0000;
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b1;
      @(posedge clk); #1;

      // 1: word store then word load
      do_req(1, 0, 0, 16'h0010, 16'hBEEF, 0, rd, lat, aw);
      chk("t1_store_lat", 32'(lat), 32'd2);
      chk("t1_mem10", 32'(mem[16'h0010]), 32'h00EF);
      chk("t1_mem11", 32'(mem[16'h0011]), 32'h00BE);
      do_req(0, 0, 0, 16'h0010, 16'h0000, 0, rd, lat, aw);
      chk("t1_load", 32'(rd), 32'h0000BEEF);
      chk("t1_load_lat", 32'(lat), 32'd5);

      // 2: byte store keeps the neighbouring byte
      do_req(1, 1, 0, 16'h0010, 16'h775A, 0, rd, lat, aw);
      chk("t2_bstore_lat", 32'(lat), 32'd6);
      chk("t2_bstore_rdata", 32'(rd), 32'h0);
      chk("t2_mem10", 32'(mem[16'h0010]), 32'h005A);
      chk("t2_mem11", 32'(mem[16'h0011]), 32'h00BE);
      do_req(0, 0, 0, 16'h0010, 16'h0000, 0, rd, lat, aw);
      chk("t2_load", 32'(rd), 32'h0000BE5A);

      // 3: byte loads, sign/zero extension, odd address
      do_req(1, 0, 0, 16'h0020, 16'h80EF, 0, rd, lat, aw);
      do_req(0, 1, 1, 16'h0020, 16'h0000, 0, rd, lat, aw);
      chk("t3_signed_ef", 32'(rd), 32'h0000FFEF);
      chk("t3_signed_lat", 32'(lat), 32'd5);
      do_req(0, 1, 0, 16'h0020, 16'h0000, 0, rd, lat, aw);
      chk("t3_unsigned_ef", 32'(rd), 32'h000000EF);
      do_req(0, 1, 1, 16'h0021, 16'h0000, 0, rd, lat, aw);
      chk("t3_signed_odd", 32'(rd), 32'h0000FF80);
      do_req(1, 0, 0, 16'h0020, 16'h007F, 0, rd, lat, aw);
      do_req(0, 1, 1, 16'h0020, 16'h0000, 0, rd, lat, aw);
      chk("t3_signed_7f", 32'(rd), 32'h0000007F);

      // 4: req_valid held during busy, then back-to-back request
      do_req(0, 0, 0, 16'h0010, 16'h0000, 1, rd, lat, aw);
      chk("t4_hold_load", 32'(rd), 32'h0000BE5A);
      chk("t4_hold_lat", 32'(lat), 32'd5);
      do_req(0, 1, 0, 16'h0011, 16'h0000, 0, rd, lat, aw);
      chk("t4_b2b_wait", 32'(aw), 32'd2);
      chk("t4_b2b_load", 32'(rd), 32'h000000BE);

      // 5: address wrap at 0xFFFF
      do_req(1, 0, 0, 16'hFFFF, 16'h1234, 0, rd, lat, aw);
      chk("t5_memffff", 32'(mem[16'hFFFF]), 32'h0034);
      chk("t5_mem0000", 32'(mem[16'h0000]), 32'h0012);
      do_req(0, 0, 0, 16'hFFFF, 16'h0000, 0, rd, lat, aw);
      chk("t5_load", 32'(rd), 32'h00001234);

      // 6: reset during the read phase of a byte store
      do_req(1, 0, 0, 16'h0030, 16'hAAAA, 0, rd, lat, aw);
      do_req(0, 0, 0, 16'h0030, 16'h0000, 0, rd, lat, aw);
      chk("t6_preload", 32'(rd), 32'h0000AAAA);
      bus.req_write  = 1'b1;
      bus.req_byte   = 1'b1;
      bus.req_signed = 1'b0;
      bus.req_addr   = 16'h0030;
      bus.req_wdata  = 16'h0055;
      bus.req_valid  = 1'b1;
      n = 0;
      aw = 0;
      while (!aw && n < 50) begin
         @(negedge clk);
         aw = int'(bus.req_ready);
         @(posedge clk);
         n++;
      end
      if (aw == 0) chk("t6_accept_timeout", 32'(aw), 32'd1);
      #1 bus.req_valid = 1'b0;
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("t6_rst_ready",  32'(bus.req_ready),    32'd1);
      chk("t6_rst_resp",   32'(bus.resp_valid),   32'd0);
      chk("t6_rst_rdata",  32'(bus.resp_rdata),   32'h0);
      chk("t6_rst_op",     32'(bus.mem_op),       32'd0);
      chk("t6_rst_oe",     32'(bus.mem_wdata_oe), 32'd0);
      chk("t6_rst_addr",   32'(bus.mem_addr),     32'h0);
      chk("t6_rst_wdata",  32'(bus.mem_wdata),    32'h0);
      @(posedge clk);
      #2 reset_n = 1'b1;
      repeat (TB_WAIT + 4) @(posedge clk);
      #1;
      chk("t6_ready_after", 32'(bus.req_ready), 32'd1);
      chk("t6_mem30", 32'(mem[16'h0030]), 32'h00AA);
      chk("t6_mem31", 32'(mem[16'h0031]), 32'h00AA);
      do_req(0, 0, 0, 16'h0030, 16'h0000, 0, rd, lat, aw);
      chk("t6_load", 32'(rd), 32'h0000AAAA);

      repeat (3) @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
